// File: rtl/neuron_mac.sv
// Single-neuron MAC stage: fetches NUM_INPUTS weights plus a bias from an external BRAM,
// accumulates weight*activation products over an input stream, adds the bias and applies saturating ReLU.
module neuron_mac #(
    parameter int NUM_INPUTS = 4,
    parameter int WORD_LEN   = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_LEN    = 40
) (
    input  logic                              clk_i,
    input  logic                              reset_ni,
    input  logic                              start_i,
    output logic                              busy_o,
    output logic                              w_ena_o,
    output logic [$clog2(NUM_INPUTS+1)-1:0]   w_addr_o,
    input  logic [WORD_LEN-1:0]               w_data_i,
    input  logic                              x_valid_i,
    output logic                              x_ready_o,
    input  logic [WORD_LEN-1:0]               x_data_i,
    output logic                              y_valid_o,
    input  logic                              y_ready_i,
    output logic [WORD_LEN-1:0]               y_data_o
);

    localparam int AW = $clog2(NUM_INPUTS + 1);
    localparam logic [AW-1:0] LAST_K = AW'(NUM_INPUTS);
    localparam int PW = 2 * WORD_LEN;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        MAC,
        BIAS,
        DONE
    } state_t;

    state_t                     r_state;
    logic [AW-1:0]              r_k;
    logic signed [ACC_LEN-1:0]  r_acc;
    logic [WORD_LEN-1:0]        r_weight;
    logic                       r_busy;
    logic                       r_wEna;
    logic [AW-1:0]              r_wAddr;
    logic                       r_xReady;
    logic                       r_yValid;
    logic [WORD_LEN-1:0]        r_yData;

    logic signed [PW-1:0]       w_xExt;
    logic signed [PW-1:0]       w_wExt;
    logic signed [PW-1:0]       w_prod;
    logic signed [ACC_LEN-1:0]  w_prodExt;
    logic signed [ACC_LEN-1:0]  w_biasExt;
    logic signed [ACC_LEN-1:0]  w_accMac;
    logic signed [ACC_LEN-1:0]  w_accBias;
    logic signed [ACC_LEN-1:0]  w_shift;
    logic [AW-1:0]              w_kNext;
    logic [WORD_LEN-1:0]        w_satY;

    // Full-width signed product; operands fit so the low PW bits are exact
    assign w_xExt    = {{WORD_LEN{x_data_i[WORD_LEN-1]}}, x_data_i};
    assign w_wExt    = {{WORD_LEN{r_weight[WORD_LEN-1]}}, r_weight};
    assign w_prod    = w_xExt * w_wExt;
    assign w_prodExt = {{(ACC_LEN-PW){w_prod[PW-1]}}, w_prod};
    // Bias is aligned to the product's 2*FRAC_BITS binary point
    assign w_biasExt = {{(ACC_LEN-WORD_LEN-FRAC_BITS){r_weight[WORD_LEN-1]}}, r_weight, {FRAC_BITS{1'b0}}};
    assign w_accMac  = r_acc + w_prodExt;
    assign w_accBias = r_acc + w_biasExt;
    assign w_shift   = w_accBias >>> FRAC_BITS;
    assign w_kNext   = r_k + AW'(1);

    always_comb begin
        w_satY = w_shift[WORD_LEN-1:0];
        if (w_shift[ACC_LEN-1]) begin
            w_satY = '0;
        end else if (|w_shift[ACC_LEN-1:WORD_LEN-1]) begin
            w_satY = {1'b0, {(WORD_LEN-1){1'b1}}};
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            r_state  <= IDLE;
            r_k      <= '0;
            r_acc    <= '0;
            r_weight <= '0;
            r_busy   <= 1'b0;
            r_wEna   <= 1'b0;
            r_wAddr  <= '0;
            r_xReady <= 1'b0;
            r_yValid <= 1'b0;
            r_yData  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start_i) begin
                        r_state <= FETCH;
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_busy  <= 1'b1;
                        r_wEna  <= 1'b1;
                        r_wAddr <= '0;
                    end
                end
                FETCH: begin
                    r_wEna  <= 1'b0;
                    r_state <= LOAD;
                end
                LOAD: begin
                    r_weight <= w_data_i;
                    if (r_k < LAST_K) begin
                        r_state  <= MAC;
                        r_xReady <= 1'b1;
                    end else begin
                        r_state <= BIAS;
                    end
                end
                MAC: begin
                    if (x_valid_i) begin
                        r_acc    <= w_accMac;
                        r_k      <= w_kNext;
                        r_xReady <= 1'b0;
                        r_wEna   <= 1'b1;
                        r_wAddr  <= w_kNext;
                        r_state  <= FETCH;
                    end
                end
                BIAS: begin
                    r_acc    <= w_accBias;
                    r_yData  <= w_satY;
                    r_yValid <= 1'b1;
                    r_state  <= DONE;
                end
                DONE: begin
                    if (y_ready_i) begin
                        r_yValid <= 1'b0;
                        r_busy   <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o    = r_busy;
    assign w_ena_o   = r_wEna;
    assign w_addr_o  = r_wAddr;
    assign x_ready_o = r_xReady;
    assign y_valid_o = r_yValid;
    assign y_data_o  = r_yData;

endmodule

// File: tb/tb_neuron_mac.sv
// Randomized self-checking bench for neuron_mac: a BRAM model feeds weights, an arithmetic
// reference computes the expected neuron output, and every meaningful cycle is checked.
module tb_neuron_mac;

    localparam int N    = 4;
    localparam int FRAC = 8;

    logic        clk_i = 1'b0;
    logic        reset_ni;
    logic        start_i;
    logic        busy_o;
    logic        w_ena_o;
    logic [2:0]  w_addr_o;
    logic [15:0] w_data_i;
    logic        x_valid_i;
    logic        x_ready_o;
    logic [15:0] x_data_i;
    logic        y_valid_o;
    logic        y_ready_i;
    logic [15:0] y_data_o;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] tWeights [0:N];
    logic [15:0] tX       [0:N-1];
    int          tXStall  [0:N-1];
    int          tYStall;
    int          tStartPulseAt;
    int          tAbortAtX;

    neuron_mac dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .start_i   (start_i),
        .busy_o    (busy_o),
        .w_ena_o   (w_ena_o),
        .w_addr_o  (w_addr_o),
        .w_data_i  (w_data_i),
        .x_valid_i (x_valid_i),
        .x_ready_o (x_ready_o),
        .x_data_i  (x_data_i),
        .y_valid_o (y_valid_o),
        .y_ready_i (y_ready_i),
        .y_data_o  (y_data_o)
    );

    // Free-running clock
    always #5 clk_i = ~clk_i;

    // Parameter BRAM model: read data appears one cycle after the enable
    always @(posedge clk_i) begin
        if (w_ena_o && w_addr_o <= 3'd4) begin
            w_data_i <= tWeights[w_addr_o];
        end
    end

    // Reference: exact fixed-point sum, floor shift, then clamp to [0, 0x7FFF]
    function automatic logic [15:0] modelNeuron();
        longint acc;
        longint r;
        acc = 0;
        for (int i = 0; i < N; i++) begin
            acc += longint'($signed(tX[i])) * longint'($signed(tWeights[i]));
        end
        acc += longint'($signed(tWeights[N])) * (longint'(1) << FRAC);
        r = acc >>> FRAC;
        if (r < 0) return 16'h0000;
        if (r > 32767) return 16'h7FFF;
        return r[15:0];
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input string name, input int lit);
        logic [15:0] expY;
        int idx, expLat, xIdx, xStallDone, yStallDone, expAddr;
        bit seenValid, done, aborted;
        expY = modelNeuron();
        if (lit >= 0) checkOutput({name, "_modelPin"}, expY, lit);
        expLat = 15;
        for (int j = 0; j < N; j++) expLat += tXStall[j];
        idx = 0; xIdx = 0; xStallDone = 0; yStallDone = 0; expAddr = 0;
        seenValid = 0; done = 0; aborted = 0;

        @(negedge clk_i);
        checkOutput({name, "_idleBusy"}, busy_o, 0);
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;

        while (!done && !aborted && idx < 400) begin
            if (tAbortAtX >= 0 && x_ready_o && xIdx == tAbortAtX) begin
                reset_ni  = 1'b0;
                x_valid_i = 1'b0;
                #1;
                checkOutput({name, "_abortBusy"}, busy_o, 0);
                checkOutput({name, "_abortWEna"}, w_ena_o, 0);
                checkOutput({name, "_abortWAddr"}, w_addr_o, 0);
                checkOutput({name, "_abortXReady"}, x_ready_o, 0);
                checkOutput({name, "_abortYValid"}, y_valid_o, 0);
                checkOutput({name, "_abortYData"}, y_data_o, 0);
                aborted = 1;
            end else begin
                if (w_ena_o) begin
                    checkOutput({name, "_readAddr"}, w_addr_o, expAddr);
                    expAddr++;
                end
                if (y_valid_o) begin
                    if (!seenValid) begin
                        checkOutput({name, "_latency"}, idx, expLat);
                        seenValid = 1;
                    end
                    checkOutput({name, "_yData"}, y_data_o, expY);
                    if (yStallDone < tYStall) begin
                        y_ready_i = 1'b0;
                        yStallDone++;
                    end else begin
                        y_ready_i = 1'b1;
                        done = 1;
                    end
                end else begin
                    checkOutput({name, "_busy"}, busy_o, 1);
                    y_ready_i = 1'($urandom_range(0, 1));
                end
                if (!x_ready_o) begin
                    x_valid_i = 1'($urandom_range(0, 1));
                    x_data_i  = 16'($urandom);
                end else if (xIdx >= N) begin
                    checkOutput({name, "_extraX"}, xIdx, N - 1);
                    x_valid_i = 1'b0;
                end else if (xStallDone < tXStall[xIdx]) begin
                    x_valid_i = 1'b0;
                    x_data_i  = 16'($urandom);
                    xStallDone++;
                end else begin
                    x_valid_i  = 1'b1;
                    x_data_i   = tX[xIdx];
                    xIdx++;
                    xStallDone = 0;
                end
                start_i = (idx == tStartPulseAt);
                @(negedge clk_i);
                idx++;
            end
        end

        start_i   = 1'b0;
        x_valid_i = 1'b0;
        y_ready_i = 1'b0;
        if (aborted) begin
            @(negedge clk_i);
            checkOutput({name, "_abortNoValid"}, y_valid_o, 0);
            reset_ni = 1'b1;
            @(negedge clk_i);
        end else if (done) begin
            checkOutput({name, "_postYValid"}, y_valid_o, 0);
            checkOutput({name, "_postBusy"}, busy_o, 0);
            checkOutput({name, "_postYHold"}, y_data_o, expY);
            checkOutput({name, "_readCount"}, expAddr, N + 1);
            checkOutput({name, "_xCount"}, xIdx, N);
            @(negedge clk_i);
            checkOutput({name, "_idleNoFetch"}, w_ena_o, 0);
        end else begin
            checkOutput({name, "_timeout"}, 0, 1);
        end
    endtask

    task automatic setBasic();
        for (int i = 0; i < N; i++) begin
            tWeights[i] = 16'h0100;
            tX[i]       = 16'((i + 1) * 256);
            tXStall[i]  = 0;
        end
        tWeights[N]   = 16'h0080;
        tYStall       = 0;
        tStartPulseAt = -1;
        tAbortAtX     = -1;
    endtask

    initial begin
        reset_ni  = 1'b0;
        start_i   = 1'b0;
        x_valid_i = 1'b0;
        x_data_i  = '0;
        y_ready_i = 1'b0;
        setBasic();
        #3;
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_wEna", w_ena_o, 0);
        checkOutput("rst_wAddr", w_addr_o, 0);
        checkOutput("rst_xReady", x_ready_o, 0);
        checkOutput("rst_yValid", y_valid_o, 0);
        checkOutput("rst_yData", y_data_o, 0);
        @(negedge clk_i);
        @(negedge clk_i);
        reset_ni = 1'b1;

        setBasic();
        applyStimulus("basic", 16'h0A80);

        setBasic();
        for (int i = 0; i < N; i++) tWeights[i] = 16'hFF00;
        applyStimulus("relu", 0);

        setBasic();
        for (int i = 0; i < N; i++) begin
            tWeights[i] = 16'h7F00;
            tX[i]       = 16'h7F00;
        end
        tWeights[N] = 16'h0000;
        applyStimulus("saturate", 16'h7FFF);

        setBasic();
        for (int i = 0; i < N; i++) begin
            tWeights[i] = 16'h0000;
            tX[i]       = 16'h0000;
        end
        tWeights[0] = 16'h0080;
        tX[0]       = 16'hFF00;
        tWeights[N] = 16'h0000;
        applyStimulus("negFraction", 0);

        setBasic();
        tXStall[1] = 5;
        tYStall    = 3;
        applyStimulus("backpressure", 16'h0A80);

        setBasic();
        tAbortAtX = 2;
        applyStimulus("abort", -1);
        setBasic();
        applyStimulus("afterAbort", 16'h0A80);

        setBasic();
        tStartPulseAt = 5;
        applyStimulus("restartBusy", 16'h0A80);

        for (int t = 0; t < 40; t++) begin
            bit smallRange;
            smallRange = ($urandom_range(0, 2) != 0);
            for (int i = 0; i <= N; i++) begin
                tWeights[i] = smallRange ? 16'($urandom_range(0, 1023)) - 16'd512 : 16'($urandom);
            end
            for (int i = 0; i < N; i++) begin
                tX[i]      = smallRange ? 16'($urandom_range(0, 2047)) - 16'd1024 : 16'($urandom);
                tXStall[i] = $urandom_range(0, 3);
            end
            tYStall       = $urandom_range(0, 3);
            tStartPulseAt = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 20)) : -1;
            tAbortAtX     = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, N - 1)) : -1;
            applyStimulus($sformatf("rand%0d", t), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
